spio_hss_multiplexer_tx_control: RTL



---
 rtl/spio_hss_multiplexer_tx_control.sv | 98 +++++++++
 1 files changed

// File: rtl/spio_hss_multiplexer_tx_control.sv
// rtl/spio_hss_multiplexer_tx_control.sv - TX word mux: sync/comma, frame words, periodic clock correction.
// Clock correction is built only when SPIO_HSS_MULTIPLEXER_TX_CC_EN is defined.
module spio_hss_multiplexer_tx_control #(
  parameter logic [31:0] SYNC_DATA   = 32'h505050BC,
  parameter logic [3:0]  SYNC_KCHR   = 4'b0001,
  parameter logic [31:0] CC_DATA     = 32'hF7F7F7F7,
  parameter logic [3:0]  CC_KCHR     = 4'b1111,
  parameter int          CC_INTERVAL = 5000,
  parameter int          CC_LEN      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] hsl_data,
  input  logic [3:0]  hsl_kchr,
  output logic        hsl_rdy,
  input  logic        link_up,
  output logic [31:0] gtp_txdata,
  output logic [3:0]  gtp_txcharisk,
  output logic [1:0]  tx_state,
  output logic [15:0] reg_txcc
);

  typedef enum logic {ST_SYNC = 1'b0, ST_RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        cc_slot;
  logic [31:0] txdata_q, txdata_d;
  logic [3:0]  txk_q, txk_d;

`ifdef SPIO_HSS_MULTIPLEXER_TX_CC_EN
  localparam int CNT_W = (CC_INTERVAL > 2) ? $clog2(CC_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CC_INTERVAL - 1);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(CC_INTERVAL - CC_LEN);

  logic [CNT_W-1:0] cc_cnt_q, cc_cnt_d;
  logic [15:0]      txcc_q, txcc_d;

  // Free-running in both states; only reset realigns the CC cadence.
  always_comb begin
    cc_slot  = (cc_cnt_q >= CNT_START);
    cc_cnt_d = cc_cnt_q + CNT_W'(1);
    txcc_d   = txcc_q;
    if (cc_cnt_q == CNT_LAST) begin
      cc_cnt_d = '0;
      txcc_d   = txcc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_cnt_q <= '0;
      txcc_q   <= '0;
    end else begin
      cc_cnt_q <= cc_cnt_d;
      txcc_q   <= txcc_d;
    end
  end

  assign reg_txcc = txcc_q;
`else
  logic unused_cc_cfg;
  assign unused_cc_cfg = ^{CC_DATA, CC_KCHR, CC_INTERVAL, CC_LEN};
  assign cc_slot       = 1'b0;
  assign reg_txcc      = 16'd0;
`endif

  // CC has top priority so a state change never truncates a sequence.
  always_comb begin
    state_d  = link_up ? ST_RUN : ST_SYNC;
    hsl_rdy  = (state_q == ST_RUN) && !cc_slot;
    txdata_d = hsl_data;
    txk_d    = hsl_kchr;
    if (cc_slot) begin
      txdata_d = CC_DATA;
      txk_d    = CC_KCHR;
    end else if (state_q == ST_SYNC) begin
      txdata_d = SYNC_DATA;
      txk_d    = SYNC_KCHR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SYNC;
      txdata_q <= SYNC_DATA;
      txk_q    <= SYNC_KCHR;
    end else begin
      state_q  <= state_d;
      txdata_q <= txdata_d;
      txk_q    <= txk_d;
    end
  end

  assign gtp_txdata    = txdata_q;
  assign gtp_txcharisk = txk_q;
  assign tx_state      = {1'b0, state_q};

endmodule
